io_controller: RTL and testbench
================================

Name: io_controller

Overview:
- I/O and interrupt unit on the CPU side of the control unit.
- Consumes the control unit's io_* strobes and raises io_interrupt to it.
- Owns the interrupt pending/mask registers, the return-address register and the vector address, and bridges the shared 16-bit data bus to an external peripheral port bus.
- Control unit sequences are fixed one-cycle steps, so every response here is either same-cycle combinational drive or registered at the end of the strobe cycle.

Parameters:
- N_IRQ, 8: number of interrupt request lines (1..14).
- VECTOR_BASE, 16'h0010: memory address of the vector for IRQ 0; IRQ i vector is at VECTOR_BASE+i.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- io_addr  in  4  port address from control unit
- io_addr_read  in  1  io_addr valid this cycle
- io_read  in  1  sample selected port into the holding register
- io_push  in  1  drive the holding register onto d_bus
- io_write  in  1  write d_bus to the selected port
- io_store_retaddr  in  1  latch d_bus (PC) into retaddr
- io_push_retaddr  in  1  drive retaddr onto d_bus
- io_push_ints  in  1  drive the pending vector onto d_bus
- io_push_int_addr  in  1  drive the vector address onto a_bus and acknowledge
- io_interrupt  out  1  an unmasked interrupt is pending
- irq  in  N_IRQ  peripheral interrupt requests, level in, rising-edge sensitive
- port_addr  out  4  external port address
- port_wdata  out  16  external write data
- port_we  out  1  external write strobe
- port_re  out  1  external read strobe
- port_rdata  in  16  external read data, valid combinationally while port_re is high
- d_bus  inout  16  shared data bus
- a_bus  inout  16  shared memory address bus

Behaviour:
Reset (rst_n low, asynchronous):
- pending, mask, retaddr, holding and irq_prev are all 0.
- io_interrupt is 0; port_we and port_re are 0; d_bus and a_bus are Z.
- Reset mid-sequence discards any in-flight read or acknowledge.

Port address map:
- 0x0..0xD are external.
- 0xE is internal PENDING: read returns pending, zero-extended; a write clears the bits set in d_bus (write-1-to-clear).
- 0xF is internal MASK: read/write; bit i = 1 enables IRQ i.

External access (combinational):
- port_addr = io_addr.
- port_re = io_read & io_addr_read & (io_addr < 0xE).
- port_we = io_write & io_addr_read & (io_addr < 0xE).
- port_wdata = d_bus.

Read path:
- On a clk edge with io_read, holding <= the selected source (port_rdata, pending or mask).
- io_push, next cycle, drives holding onto d_bus.
- Read-to-bus latency is 1 cycle.

Interrupt capture:
- irq_prev <= irq every cycle.
- Rising edge = irq & ~irq_prev.
- Edges set pending bits.
- io_interrupt = |(pending & mask), registered-free (combinational from registers).

Acknowledge:
- io_push_int_addr drives a_bus = VECTOR_BASE + idx, where idx is the lowest-numbered set bit of (pending & mask).
- On that clk edge, pending[idx] is cleared.
- A new edge on idx in the same cycle wins: the bit stays set.
- With no active request, a_bus is driven to VECTOR_BASE and nothing is cleared.

Return address:
- io_store_retaddr: retaddr <= d_bus (the PC pushed the same cycle by the control unit).
- io_push_retaddr drives retaddr onto d_bus.
- Only one level is held; a second store overwrites it. Nesting is software's responsibility.

Other bus drives and precedence:
- io_push_ints drives {0, pending} onto d_bus.
- Simultaneous edge and W1C write on the same bit: the edge wins.
- More than one of io_push / io_push_retaddr / io_push_ints at once is illegal; priority is retaddr > ints > push; a simulation assertion flags it.

Optional Feature:
- Macro: IO_IRQ_SYNC_EN
- Defined: each irq line passes through a two-flop synchronizer before edge detection; edge-to-pending latency is 3 cycles; synchronizer flops reset to 0.
- Undefined: irq is edge-detected directly; latency is 1 cycle (pending is set at the first edge where irq=1 and irq_prev=0).

Decomposition:
- Package io_pkg holds:
  - constants IO_ADDR_PENDING = 4'hE and IO_ADDR_MASK = 4'hF;
  - the default VECTOR_BASE;
  - the localparam for the external address limit.
- One sub-module, irq_priority_encoder: combinational lowest-set-bit finder over N_IRQ bits, outputting idx and valid.

Test Plan:
1. Reset: hold rst_n=0 with irq=all-1 -> io_interrupt=0, d_bus/a_bus=Z, pending=0. After release with irq held high -> no pending (no edge).
2. mask=0x05, pulse irq[2] then irq[0] -> io_interrupt=1; io_push_int_addr drives a_bus=0x0010 and clears bit 0; a second ack drives a_bus=0x0012; io_interrupt then falls to 0.
3. io_read @0x3 with port_rdata=0xBEEF -> port_re=1 for 1 cycle; next cycle io_push gives d_bus=0xBEEF.
4. io_write @0x5 with d_bus=0x1234 -> port_we=1, port_wdata=0x1234. Write @0xF with d_bus=0x00FF -> port_we=0; a read back of 0xF returns 0x00FF.
5. pending=0x03, write 0x0001 to 0xE while irq[0] rises the same cycle -> pending stays 0x03.
6. io_store_retaddr with d_bus=0x0ABC, then io_push_retaddr -> d_bus=0x0ABC. With IO_IRQ_SYNC_EN, edge-to-io_interrupt latency measures 3 cycles.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the I/O and interrupt unit.
// IO_IRQ_SYNC_EN adds a two-flop synchronizer on every irq line.
package io_pkg;

    localparam logic [3:0]  IO_ADDR_PENDING = 4'hE;
    localparam logic [3:0]  IO_ADDR_MASK    = 4'hF;
    localparam logic [3:0]  IO_EXT_LIMIT    = 4'hE;
    localparam logic [15:0] IO_VECTOR_BASE  = 16'h0010;

`ifdef IO_IRQ_SYNC_EN
    localparam int IO_SYNC_STAGES = 2;
`else
    localparam int IO_SYNC_STAGES = 0;
`endif

    function automatic logic io_is_external(input logic [3:0] addr);
        return addr < IO_EXT_LIMIT;
    endfunction

endpackage

// File: rtl/io_controller_irq_priority_encoder.sv
// Lowest-set-bit finder over the active interrupt vector.
// idx is 0 when no bit is set; valid says whether it means anything.
module irq_priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // scan high to low so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/io_controller.sv
// I/O and interrupt unit: pending/mask, retaddr, vector, port bridge.
// Build option IO_IRQ_SYNC_EN: two-flop synchronizer on irq lines.
module io_controller
    import io_pkg::*;
#(
    parameter int          N_IRQ       = 8,
    parameter logic [15:0] VECTOR_BASE = IO_VECTOR_BASE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       io_addr,
    input  logic             io_addr_read,
    input  logic             io_read,
    input  logic             io_push,
    input  logic             io_write,
    input  logic             io_store_retaddr,
    input  logic             io_push_retaddr,
    input  logic             io_push_ints,
    input  logic             io_push_int_addr,
    output logic             io_interrupt,
    input  logic [N_IRQ-1:0] irq,
    output logic [3:0]       port_addr,
    output logic [15:0]      port_wdata,
    output logic             port_we,
    output logic             port_re,
    input  logic [15:0]      port_rdata,
    inout  wire  [15:0]      d_bus,
    inout  wire  [15:0]      a_bus
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int ARM_W = IO_SYNC_STAGES + 1;

    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] irq_det;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] w1c_bits;
    logic [N_IRQ-1:0] ack_bits;
    logic [N_IRQ-1:0] pending_next;
    logic [ARM_W-1:0] arm;
    logic             armed;
    logic [IDX_W-1:0] idx;
    logic             idx_valid;
    logic [15:0]      retaddr;
    logic [15:0]      holding;
    logic [15:0]      read_src;
    logic [15:0]      d_out;
    logic             d_oe;
    logic             a_oe;
    logic             ext;
    logic             wr;

`ifdef IO_IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1;
    logic [N_IRQ-1:0] sync2;

    // two-flop synchronizer ahead of edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end

    assign irq_det = sync2;
`else
    assign irq_det = irq;
`endif

    assign ext = io_is_external(io_addr);
    assign wr  = io_write & io_addr_read;

    assign port_addr  = io_addr;
    assign port_wdata = d_bus;
    assign port_re    = rst_n & io_read & io_addr_read & ext;
    assign port_we    = rst_n & wr & ext;

    // irq_prev is 0 out of reset; edges stay blocked until it has
    // tracked the detector input once, so a line held high across
    // reset release is not seen as a fresh request
    assign armed = arm[ARM_W-1];
    assign rise  = irq_det & ~irq_prev & {N_IRQ{armed}};

    assign active       = pending & mask;
    assign io_interrupt = |active;

    irq_priority_encoder #(
        .N     (N_IRQ),
        .IDX_W (IDX_W)
    ) u_enc (
        .req   (active),
        .idx   (idx),
        .valid (idx_valid)
    );

    assign w1c_bits = (wr && io_addr == IO_ADDR_PENDING)
                    ? d_bus[N_IRQ-1:0] : '0;
    assign ack_bits = (io_push_int_addr && idx_valid)
                    ? (N_IRQ'(1) << idx) : '0;

    // a same-cycle edge beats both W1C and acknowledge clears
    assign pending_next = (pending & ~(w1c_bits | ack_bits)) | rise;

    // select the source sampled into the holding register
    always_comb begin
        read_src = port_rdata;
        unique case (1'b1)
            (io_addr == IO_ADDR_PENDING): read_src = 16'(pending);
            (io_addr == IO_ADDR_MASK):    read_src = 16'(mask);
            default: ;
        endcase
    end

    // d_bus source, retaddr over pending over holding
    always_comb begin
        d_out = holding;
        if (io_push_retaddr) begin
            d_out = retaddr;
        end else if (io_push_ints) begin
            d_out = 16'(pending);
        end
    end

    assign d_oe = rst_n & (io_push | io_push_retaddr | io_push_ints);
    assign a_oe = rst_n & io_push_int_addr;

    assign d_bus = d_oe ? d_out : 'z;
    assign a_bus = a_oe ? (VECTOR_BASE + 16'(idx)) : 'z;

    // interrupt state: edge history, arming, pending and mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev <= '0;
            arm      <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            irq_prev <= irq_det;
            arm      <= (arm << 1) | ARM_W'(1);
            pending  <= pending_next;
            if (wr && io_addr == IO_ADDR_MASK) begin
                mask <= d_bus[N_IRQ-1:0];
            end
        end
    end

    // data registers: return address and read holding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retaddr <= '0;
            holding <= '0;
        end else begin
            if (io_store_retaddr) begin
                retaddr <= d_bus;
            end
            if (io_read) begin
                holding <= read_src;
            end
        end
    end

    a_one_push: assert property (
        @(posedge clk) disable iff (!rst_n)
        $onehot0({io_push, io_push_retaddr, io_push_ints})
    );

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller with a behavioural model.
// Honours IO_IRQ_SYNC_EN for the edge-to-pending latency.
module tb_io_controller;

`ifdef IO_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  io_addr = '0;
    logic        io_addr_read = 1'b0;
    logic        io_read = 1'b0;
    logic        io_push = 1'b0;
    logic        io_write = 1'b0;
    logic        io_store_retaddr = 1'b0;
    logic        io_push_retaddr = 1'b0;
    logic        io_push_ints = 1'b0;
    logic        io_push_int_addr = 1'b0;
    wire         io_interrupt;
    logic [7:0]  irq = 8'hFF;
    wire  [3:0]  port_addr;
    wire  [15:0] port_wdata;
    wire         port_we;
    wire         port_re;
    logic [15:0] port_rdata = '0;
    wire  [15:0] d_bus;
    wire  [15:0] a_bus;
    logic [15:0] tb_d = 16'h5A5A;
    logic [15:0] tb_a = 16'h5A5A;
    logic        tb_d_en = 1'b1;
    logic        tb_a_en = 1'b1;

    assign d_bus = tb_d_en ? tb_d : 'z;
    assign a_bus = tb_a_en ? tb_a : 'z;

    always #5 clk = ~clk;

    io_controller #(
        .N_IRQ       (8),
        .VECTOR_BASE (16'h0010)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .io_addr          (io_addr),
        .io_addr_read     (io_addr_read),
        .io_read          (io_read),
        .io_push          (io_push),
        .io_write         (io_write),
        .io_store_retaddr (io_store_retaddr),
        .io_push_retaddr  (io_push_retaddr),
        .io_push_ints     (io_push_ints),
        .io_push_int_addr (io_push_int_addr),
        .io_interrupt     (io_interrupt),
        .irq              (irq),
        .port_addr        (port_addr),
        .port_wdata       (port_wdata),
        .port_we          (port_we),
        .port_re          (port_re),
        .port_rdata       (port_rdata),
        .d_bus            (d_bus),
        .a_bus            (a_bus)
    );

    // ---------------- behavioural model ----------------
    logic [7:0]  m_pend, m_mask, m_prev, m_h1, m_h2;
    logic [7:0]  m_eff, m_rise, m_clr;
    logic [15:0] m_ret, m_hold;
    int          m_since;
    int          m_k;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        m_pend = '0; m_mask = '0; m_prev = '0;
        m_h1 = '0; m_h2 = '0; m_ret = '0; m_hold = '0;
        m_since = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pend = '0; m_mask = '0; m_prev = '0;
                m_h1 = '0; m_h2 = '0; m_ret = '0; m_hold = '0;
                m_since = 0;
            end else begin
                m_eff  = (LAT == 3) ? m_h2 : irq;
                m_rise = (m_since >= LAT) ? (m_eff & ~m_prev) : 8'h00;
                m_clr  = 8'h00;
                if (io_write && io_addr_read && io_addr == 4'hE)
                    m_clr = m_clr | d_bus[7:0];
                m_k = lowest(m_pend & m_mask);
                if (io_push_int_addr && m_k >= 0)
                    m_clr[m_k] = 1'b1;
                if (io_read) begin
                    if (io_addr == 4'hE)      m_hold = {8'h00, m_pend};
                    else if (io_addr == 4'hF) m_hold = {8'h00, m_mask};
                    else                      m_hold = port_rdata;
                end
                if (io_write && io_addr_read && io_addr == 4'hF)
                    m_mask = d_bus[7:0];
                if (io_store_retaddr)
                    m_ret = d_bus;
                m_pend = (m_pend & ~m_clr) | m_rise;
                m_h2 = m_h1;
                m_h1 = irq;
                m_prev = m_eff;
                m_since++;
            end
        end
    end

    // ---------------- literal expectations ----------------
    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
        logic [15:0] got;
    } lit_t;

    lit_t lits [128];
    int   lit_wr = 0;

    task automatic expect_lit(input string name, input int sel,
                              input logic [15:0] exp,
                              input logic [15:0] got = 16'h0);
        lits[lit_wr] = '{name, sel, exp, got};
        lit_wr++;
    endtask

    // ---------------- compare process ----------------
    int checks = 0;
    int errors = 0;
    int lit_rd = 0;
    logic [15:0] c_got, c_exp;
    int c_k;

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("io_interrupt", 16'(io_interrupt),
                16'(rst_n && ((m_pend & m_mask) != 0)));
            chk("port_re", 16'(port_re),
                16'(rst_n && io_read && io_addr_read && io_addr < 4'hE));
            chk("port_we", 16'(port_we),
                16'(rst_n && io_write && io_addr_read && io_addr < 4'hE));
            chk("port_addr", 16'(port_addr), 16'(io_addr));
            if (rst_n && (io_push || io_push_retaddr || io_push_ints)) begin
                c_exp = io_push_retaddr ? m_ret
                      : io_push_ints    ? {8'h00, m_pend}
                      :                   m_hold;
                chk("d_bus", d_bus, c_exp);
            end
            if (rst_n && io_push_int_addr) begin
                c_k = lowest(m_pend & m_mask);
                chk("a_bus", a_bus, 16'h0010 + 16'(c_k < 0 ? 0 : c_k));
            end
            while (lit_rd < lit_wr) begin
                case (lits[lit_rd].sel)
                    0: c_got = 16'(io_interrupt);
                    1: c_got = d_bus;
                    2: c_got = a_bus;
                    3: c_got = 16'(port_re);
                    4: c_got = 16'(port_we);
                    5: c_got = port_wdata;
                    6: c_got = {8'h00, m_pend};
                    default: c_got = lits[lit_rd].got;
                endcase
                chk(lits[lit_rd].name, c_got, lits[lit_rd].exp);
                lit_rd++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle();
        io_addr_read     = 1'b0;
        io_read          = 1'b0;
        io_push          = 1'b0;
        io_write         = 1'b0;
        io_store_retaddr = 1'b0;
        io_push_retaddr  = 1'b0;
        io_push_ints     = 1'b0;
        io_push_int_addr = 1'b0;
        tb_d_en          = 1'b0;
    endtask

    int lat;

    initial begin
        // reset with all irq lines high, buses released by the DUT
        expect_lit("rst_int", 0, 16'h0000);
        expect_lit("rst_dbus_z", 1, 16'h5A5A);
        expect_lit("rst_abus_z", 2, 16'h5A5A);
        expect_lit("rst_pend", 6, 16'h0000);
        cyc(2);
        rst_n = 1'b1;
        tb_d_en = 1'b0;
        tb_a_en = 1'b0;
        cyc(5);
        expect_lit("no_edge_pend", 6, 16'h0000);
        expect_lit("no_edge_int", 0, 16'h0000);
        cyc(1);
        irq = 8'h00;
        cyc(5);

        // mask 0x05, pulse irq2 then irq0, two acknowledges
        io_addr = 4'hF; io_addr_read = 1'b1; io_write = 1'b1;
        tb_d_en = 1'b1; tb_d = 16'h0005;
        expect_lit("mask_wr_we", 4, 16'h0000);
        cyc(1);
        idle();
        irq = 8'h04;
        cyc(1);
        irq = 8'h01;
        cyc(1);
        irq = 8'h00;
        cyc(4);
        expect_lit("pend_05", 6, 16'h0005);
        expect_lit("int_hi", 0, 16'h0001);
        cyc(1);
        io_push_int_addr = 1'b1;
        expect_lit("ack0_abus", 2, 16'h0010);
        cyc(1);
        expect_lit("ack2_abus", 2, 16'h0012);
        cyc(1);
        idle();
        expect_lit("int_lo", 0, 16'h0000);
        expect_lit("pend_0", 6, 16'h0000);
        cyc(1);

        // external read, one-cycle latency to d_bus
        io_addr = 4'h3; io_addr_read = 1'b1; io_read = 1'b1;
        port_rdata = 16'hBEEF;
        expect_lit("rd_re", 3, 16'h0001);
        cyc(1);
        idle();
        port_rdata = 16'h0000;
        io_push = 1'b1;
        expect_lit("rd_re_off", 3, 16'h0000);
        expect_lit("rd_dbus", 1, 16'hBEEF);
        cyc(1);
        idle();

        // external write, then internal mask write and read back
        io_addr = 4'h5; io_addr_read = 1'b1; io_write = 1'b1;
        tb_d_en = 1'b1; tb_d = 16'h1234;
        expect_lit("wr_we", 4, 16'h0001);
        expect_lit("wr_wdata", 5, 16'h1234);
        cyc(1);
        io_addr = 4'hF; tb_d = 16'h00FF;
        expect_lit("mask_we", 4, 16'h0000);
        cyc(1);
        idle();
        io_addr = 4'hF; io_addr_read = 1'b1; io_read = 1'b1;
        port_rdata = 16'hDEAD;
        expect_lit("mask_rd_re", 3, 16'h0000);
        cyc(1);
        idle();
        io_push = 1'b1;
        expect_lit("mask_rd", 1, 16'h00FF);
        cyc(1);
        idle();

        // edge beats a same-cycle W1C on the same bit
        irq = 8'h03;
        cyc(1);
        irq = 8'h00;
        cyc(4);
        expect_lit("pend_03", 6, 16'h0003);
        cyc(1);
        irq = 8'h01;
        if (LAT > 1) cyc(LAT - 1);
        io_addr = 4'hE; io_addr_read = 1'b1; io_write = 1'b1;
        tb_d_en = 1'b1; tb_d = 16'h0001;
        cyc(1);
        idle();
        io_push_ints = 1'b1;
        expect_lit("w1c_lose", 6, 16'h0003);
        expect_lit("ints_dbus", 1, 16'h0003);
        cyc(1);
        idle();
        io_addr = 4'hE; io_addr_read = 1'b1; io_write = 1'b1;
        tb_d_en = 1'b1; tb_d = 16'h0003;
        cyc(1);
        idle();
        irq = 8'h00;
        expect_lit("w1c_clr", 6, 16'h0000);
        cyc(1);

        // return address store, push and overwrite
        io_store_retaddr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h0ABC;
        cyc(1);
        idle();
        io_push_retaddr = 1'b1;
        expect_lit("ret_abc", 1, 16'h0ABC);
        cyc(1);
        idle();
        io_store_retaddr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h1111;
        cyc(1);
        idle();
        io_push_retaddr = 1'b1;
        expect_lit("ret_over", 1, 16'h1111);
        cyc(1);
        idle();
        cyc(1);

        // edge-to-interrupt latency, bounded
        irq = 8'h20;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (io_interrupt) begin
                lat = k;
                break;
            end
        end
        #1;
        expect_lit("irq_latency", 7, 16'(LAT), 16'(lat));
        cyc(1);
        io_push_int_addr = 1'b1;
        expect_lit("ack5_abus", 2, 16'h0015);
        cyc(1);
        expect_lit("ack_none", 2, 16'h0010);
        expect_lit("ack_none_int", 0, 16'h0000);
        cyc(1);
        idle();
        irq = 8'h00;
        expect_lit("ack_none_pend", 6, 16'h0000);
        cyc(1);

        // reset in the middle of a read discards it
        io_addr = 4'h3; io_addr_read = 1'b1; io_read = 1'b1;
        port_rdata = 16'hCAFE;
        cyc(1);
        idle();
        rst_n = 1'b0;
        io_push = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        expect_lit("rst_discard", 1, 16'h0000);
        cyc(1);
        idle();
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
